// File: rtl/conv_output_packer.sv
// Write-back packer for the 3x3 convolution datapath: follows raster position on
// a delayed pixel-valid, drops invalid-window results, emits a packed addressed stream.
module conv_output_packer #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int LAT          = 3,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        stage_width,
  input  logic [7:0]        stage_height,
  input  logic              pix_valid,
  input  logic [7:0]        data_in,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [8:0] MAX_W = 9'(IMAGE_WIDTH);
  localparam logic [8:0] MAX_H = 9'(IMAGE_HEIGHT);

  state_t            state_q, state_d;
  logic [LAT-1:0]    dly_q;
  logic              dv;
  logic [7:0]        w_q, w_d;
  logic [7:0]        h_q, h_d;
  logic [7:0]        r_q, r_d;
  logic [7:0]        c_q, c_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              ov_q, ov_d;
  logic [7:0]        od_q, od_d;
  logic [ADDR_W-1:0] oa_q, oa_d;
  logic              ol_q, ol_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic size_ok;
  logic beat_valid;
  logic beat_last;
  logic col_wrap;

  // Pixel-valid delay line; its tail lines up with the MAC result on data_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples the pre-edge value of its neighbour, giving a true shift.
      dly_q[0] <= pix_valid;
      for (int i = 1; i < LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign dv = dly_q[LAT-1];

  assign size_ok = (stage_width  >= 8'd3) && ({1'b0, stage_width}  <= MAX_W) &&
                   (stage_height >= 8'd3) && ({1'b0, stage_height} <= MAX_H);

  assign beat_valid = (r_q >= 8'd2) && (c_q >= 8'd2);
  assign beat_last  = (r_q == h_q - 8'd1) && (c_q == w_q - 8'd1);
  assign col_wrap   = (c_q == w_q - 8'd1);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    r_d     = r_q;
    c_d     = c_q;
    addr_d  = addr_q;
    err_d   = err_q;
    ov_d    = 1'b0;
    od_d    = 8'd0;
    oa_d    = '0;
    ol_d    = 1'b0;
    busy_d  = (state_q == ARMED) || (state_q == RUN);
    done_d  = (state_q == DONE);

    unique case (state_q)
      IDLE: ;
      ARMED: begin
        // The first beat is raster (0,0); widths are at least 3, so no wrap here.
        if (dv) begin
          r_d     = 8'd0;
          c_d     = 8'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dv) begin
          if (beat_valid) begin
            ov_d   = 1'b1;
            od_d   = data_in;
            oa_d   = addr_q;
            ol_d   = beat_last;
            addr_d = addr_q + ADDR_W'(1);
          end
          if (col_wrap) begin
            c_d = 8'd0;
            r_d = r_q + 8'd1;
          end else begin
            c_d = c_q + 8'd1;
          end
          if (beat_last) begin
            state_d = DONE;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A start wins over everything else, including a coincident final beat.
    if (start) begin
      ov_d = 1'b0;
      od_d = 8'd0;
      oa_d = '0;
      ol_d = 1'b0;
      if (size_ok) begin
        w_d     = stage_width;
        h_d     = stage_height;
        r_d     = 8'd0;
        c_d     = 8'd0;
        addr_d  = '0;
        err_d   = 1'b0;
        state_d = ARMED;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= 8'd0;
      h_q     <= 8'd0;
      r_q     <= 8'd0;
      c_q     <= 8'd0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= 8'd0;
      oa_q    <= '0;
      ol_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      r_q     <= r_d;
      c_q     <= c_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oa_q    <= oa_d;
      ol_q    <= ol_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_addr  = oa_q;
  assign out_last  = ol_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_conv_output_packer.sv
// Scoreboard bench for conv_output_packer: stimulus pushes expected results,
// a negedge monitor pops and compares whatever the packer emits.
module tb_conv_output_packer;

  localparam int LAT    = 3;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [7:0]        stage_width;
  logic [7:0]        stage_height;
  logic              pix_valid;
  logic [7:0]        data_in;
  logic              out_valid;
  logic [7:0]        out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct {
    logic [7:0]        d;
    logic [ADDR_W-1:0] a;
    logic              l;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   n_out     = 0;
  int   done_cnt  = 0;
  int   exp_done  = 0;
  logic prev_last = 1'b0;

  conv_output_packer #(
    .IMAGE_WIDTH (128),
    .IMAGE_HEIGHT(128),
    .LAT         (LAT),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stage_width (stage_width),
    .stage_height(stage_height),
    .pix_valid   (pix_valid),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out: actual addr=%0d data=%0h, expected no output", out_addr, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.d));
        check("out_addr", 32'(out_addr), 32'(e.a));
        check("out_last", 32'(out_last), 32'(e.l));
      end
      n_out++;
    end else if (out_last) begin
      check("last_without_valid", 32'(out_last), 32'd0);
    end
    if (done || prev_last) check("done_follows_last", 32'(done), 32'(prev_last));
    if (done) done_cnt++;
    prev_last = out_valid && out_last;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input int w, input int h);
    @(posedge clk); #1;
    start        = 1'b1;
    stage_width  = 8'(w);
    stage_height = 8'(h);
    @(posedge clk); #1;
    start        = 1'b0;
  endtask

  // Drives one frame: stop_after truncates it, gap_after inserts one idle cycle,
  // start_at re-issues start in the cycle that pixel's result reaches the packer.
  task automatic run_frame(input int w, input int h, input int off,
                           input int gap_after, input int stop_after, input int start_at);
    logic pvq[$];
    int   pixq[$];
    int   n, a, len;
    n = (stop_after >= 0) ? stop_after + 1 : w * h;
    a = 0;
    for (int k = 0; k < n; k++) begin
      pvq.push_back(1'b1);
      pixq.push_back(k);
      if (k == gap_after) begin
        pvq.push_back(1'b0);
        pixq.push_back(0);
      end
      if ((k / w) >= 2 && (k % w) >= 2) begin
        if (!(start_at >= 0 && k >= start_at)) begin
          exp_t e;
          e.d = 8'(k + off);
          e.a = ADDR_W'(a);
          e.l = (k == w * h - 1);
          sb.push_back(e);
        end
        a++;
      end
    end
    if (n == w * h && start_at < 0) exp_done++;
    do_start(w, h);
    len = pvq.size();
    for (int i = 0; i < len + LAT; i++) begin
      @(posedge clk); #1;
      pix_valid = (i < len) ? pvq[i] : 1'b0;
      data_in   = (i >= LAT && pvq[i-LAT]) ? 8'(pixq[i-LAT] + off) : 8'd0;
      start     = (start_at >= 0 && i >= LAT && pvq[i-LAT] && pixq[i-LAT] == start_at);
      if (i == 1) check("busy_in_frame", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    data_in   = 8'd0;
    start     = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst_n        = 1'b0;
    start        = 1'b0;
    stage_width  = 8'd0;
    stage_height = 8'd0;
    pix_valid    = 1'b0;
    data_in      = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_addr",  32'(out_addr),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    rst_n = 1'b1;

    // Basic 4x4 frame: results 10,11,14,15 at addresses 0..3.
    run_frame(4, 4, 0, -1, -1, -1);
    drain();
    check("f4x4_err",  32'(err),      32'd0);
    check("f4x4_busy", 32'(busy),     32'd0);
    check("f4x4_done", 32'(done_cnt), 32'(exp_done));

    // 5x4 with a one-cycle hole after pixel 7: err sticks, frame still completes.
    run_frame(5, 4, 8'h30, 7, -1, -1);
    drain();
    check("gap_err",  32'(err),      32'd1);
    check("gap_done", 32'(done_cnt), 32'(exp_done));
    repeat (5) @(posedge clk);
    #1;
    check("gap_err_sticky", 32'(err), 32'd1);

    // Next legal start clears err.
    run_frame(4, 4, 8'h40, -1, -1, -1);
    drain();
    check("clear_err", 32'(err),      32'd0);
    check("clear_done", 32'(done_cnt), 32'(exp_done));

    // Illegal sizes.
    base = n_out;
    do_start(2, 4);
    repeat (3) @(posedge clk);
    #1;
    check("w2_err",  32'(err),  32'd1);
    check("w2_busy", 32'(busy), 32'd0);
    do_start(130, 4);
    repeat (3) @(posedge clk);
    #1;
    check("w130_err",  32'(err),  32'd1);
    check("w130_busy", 32'(busy), 32'd0);
    do_start(4, 129);
    repeat (3) @(posedge clk);
    #1;
    check("h129_busy", 32'(busy),  32'd0);
    check("illegal_no_out", 32'(n_out - base), 32'd0);

    // Abort after pixel 9, then a fresh 4x4 frame.
    run_frame(4, 4, 8'h50, -1, 9, -1);
    run_frame(4, 4, 8'h60, -1, -1, -1);
    drain();
    check("abort_err",  32'(err),      32'd0);
    check("abort_done", 32'(done_cnt), 32'(exp_done));

    // start coincident with the final beat suppresses its output and done.
    run_frame(4, 4, 8'h70, -1, -1, 15);
    run_frame(4, 4, 8'h90, -1, -1, -1);
    drain();
    check("startlast_done", 32'(done_cnt), 32'(exp_done));

    // Full-size frame.
    base = n_out;
    run_frame(128, 128, 8'h05, -1, -1, -1);
    drain();
    check("big_count", 32'(n_out - base), 32'd15876);
    check("big_err",   32'(err),          32'd0);
    check("big_done",  32'(done_cnt),     32'(exp_done));

    // Reset in the middle of a 4x4 frame, right as the first result is out.
    begin
      exp_t e;
      e.d = 8'(10 + 8'h20);
      e.a = '0;
      e.l = 1'b0;
      sb.push_back(e);
    end
    do_start(4, 4);
    for (int i = 0; i <= 11 + LAT; i++) begin
      @(posedge clk); #1;
      pix_valid = (i < 16);
      data_in   = (i >= LAT) ? 8'(i - LAT + 8'h20) : 8'd0;
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data",  32'(out_data),  32'd0);
    check("arst_out_addr",  32'(out_addr),  32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_queue",     32'(sb.size()), 32'd0);
    pix_valid = 1'b0;
    data_in   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = n_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      pix_valid = 1'b1;
      data_in   = 8'(i);
    end
    pix_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_out", 32'(n_out - base), 32'd0);
    check("post_rst_busy",   32'(busy),         32'd0);
    check("post_rst_done",   32'(done_cnt),     32'(exp_done));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
